spike_out_collector: RTL
========================

# spike_out_collector

Downstream consumer of the neuron core's output spike queue. Drains spike indices (one postsynaptic neuron index per entry) from the show-ahead output FIFO, builds a per-timestep spike bitmap and per-neuron cumulative spike counts. At the end of each timestep it presents the bitmap to the host/next layer through a valid/ready handshake. Sits between `n_core`'s L2 output queue ports and the host readout logic.

## Interface
- `N`, 8, number of neurons (valid indices 0..N-1)
- `B`, 8, FIFO data width (spike index width)
- `CW`, 8, per-neuron spike counter width
- `SW`, 16, timestep counter width
- `clk_i`  in  1  clock; all state on rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `en_i`  in  1  enables draining the FIFO
- `fifo_empty_i`  in  1  output queue empty
- `fifo_r_data_i`  in  B  queue head (show-ahead, valid while !empty)
- `fifo_rd_o`  out  1  pop strobe to output queue
- `step_done_i`  in  1  single-cycle pulse from core: timestep's spikes all written
- `clear_i`  in  1  synchronous clear of spike counters and drop counter
- `rd_idx_i`  in  $clog2(N)  counter readout select
- `rd_count_o`  out  CW  count of neuron `rd_idx_i` (combinational mux)
- `frame_valid_o`  out  1  timestep bitmap valid
- `frame_bitmap_o`  out  N  bit i = neuron i spiked in presented timestep
- `frame_ready_i`  in  1  consumer accepts frame
- `step_cnt_o`  out  SW  number of frames accepted
- `drop_cnt_o`  out  8  out-of-range indices seen (saturating)
- `busy_o`  out  1  high when state != RUN or pending step or FIFO non-empty with en_i

## Operation
- FSM states: RUN, FLUSH, PRESENT. Reset state RUN.
- `fifo_rd_o` = (state is RUN or FLUSH) && `en_i` && !`fifo_empty_i`; combinational, no FIFO read in PRESENT.
- On each pop: idx = `fifo_r_data_i`. If idx < N: set `bitmap[idx]`, increment `count[idx]` saturating at 2^CW-1. Else: no bitmap/count change, `drop_cnt` +1 saturating at 255.
- Duplicate index in same step: bitmap bit stays 1, count increments again.
- RUN: `step_done_i` -> FLUSH (or pending flag set, see below).
- FLUSH: keeps popping; when `fifo_empty_i` (or !`en_i` with empty FIFO) at a clock edge with no pop -> PRESENT, latch bitmap into `frame_bitmap_o`, assert `frame_valid_o`.
- PRESENT: hold `frame_valid_o`/`frame_bitmap_o` stable until `frame_valid_o && frame_ready_i` on an edge; then clear working bitmap, `step_cnt` +1 (wraps at 2^SW), -> RUN (or FLUSH if pending).
- `step_done_i` while in FLUSH or PRESENT: sets a single pending flag (further pulses merge); on leaving PRESENT with pending set -> FLUSH, clear pending.
- `en_i` low: no pops; FSM transitions still occur (FLUSH can complete only if FIFO empty).
- `clear_i`: zero all `count[]` and `drop_cnt` next edge; clear takes priority over a same-cycle increment. Does not affect bitmap, frame, FSM or `step_cnt`.
- Reset (any time, including mid-FLUSH/PRESENT): state RUN, pending 0, bitmap 0, counts 0, `frame_valid_o`=0, `frame_bitmap_o`=0, `step_cnt_o`=0, `drop_cnt_o`=0; `fifo_rd_o` low immediately (asynchronously) while `rst_i` high.

## Timing
- Pop to bitmap/count update: 1 cycle (visible edge after pop).
- `step_done_i` with empty FIFO in RUN: FLUSH next edge, `frame_valid_o` high 2 cycles after pulse edge.
- Frame throughput: one frame per handshake; `frame_ready_i` held high -> valid lasts exactly 1 cycle.
- `rd_count_o` reflects register state combinationally, zero-cycle from `rd_idx_i`.
- Max drain rate: one entry per cycle.

## Test plan
- Reset: assert `rst_i` mid-PRESENT with bitmap 0x05 -> all outputs 0, `fifo_rd_o`=0, FSM RUN.
- FIFO holds 1,3,3,7; `en_i`=1, pulse `step_done_i`, `frame_ready_i`=1 -> 4 pops on consecutive cycles, frame bitmap 0x8A, count[3]=2, count[1]=1, count[7]=1, `step_cnt_o`=1.
- FIFO holds 2, 9, 200 (N=8) -> bitmap 0x04, `drop_cnt_o`=2, no counts for 9/200.
- Back-pressure: `frame_ready_i`=0 for 5 cycles with 0x11 presented, push index 4 into FIFO meanwhile -> bitmap stable 0x11, no pops; after ready, next frame bitmap 0x10.
- `step_done_i` pulsed twice during PRESENT -> exactly one extra frame generated after handshake, `step_cnt_o` ends +2.
- count[0] driven to 255 then one more spike -> stays 255; `clear_i` same cycle as a pop of 0 -> count[0]=0.

Source files
------------

// File: rtl/spike_out_collector.sv
`default_nettype none
// ============================================================================
//  Module      : spike_out_collector
//  Description : Drains spike indices from a show-ahead output FIFO, builds a
//                per-timestep spike bitmap plus saturating per-neuron spike
//                counts, and presents each timestep's bitmap through a
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_out_collector #(
  parameter int N  = 8,
  parameter int B  = 8,
  parameter int CW = 8,
  parameter int SW = 16,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          fifo_empty_i,
  input  logic [B-1:0]  fifo_r_data_i,
  output logic          fifo_rd_o,
  input  logic          step_done_i,
  input  logic          clear_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [CW-1:0] rd_count_o,
  output logic          frame_valid_o,
  output logic [N-1:0]  frame_bitmap_o,
  input  logic          frame_ready_i,
  output logic [SW-1:0] step_cnt_o,
  output logic [7:0]    drop_cnt_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_FLUSH   = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_pending;
  logic            w_pending_nxt;
  logic [N-1:0]    r_bitmap;
  logic [N-1:0]    r_frame_bitmap;
  logic [CW-1:0]   r_count [N];
  logic [7:0]      r_drop_cnt;
  logic [SW-1:0]   r_step_cnt;

  logic            w_pop;
  logic            w_in_range;
  logic [IW-1:0]   w_idx;
  logic            w_enter_present;
  logic            w_handshake;

  // Pop strobe: masked asynchronously by reset, never issued while presenting
  assign w_pop = !rst_i && (r_state != S_PRESENT) && en_i && !fifo_empty_i;
  assign w_in_range = (int'(fifo_r_data_i) < N);
  assign w_idx = fifo_r_data_i[IW-1:0];
  // FLUSH completes on an edge where the FIFO is empty (so no pop happens)
  assign w_enter_present = (r_state == S_FLUSH) && fifo_empty_i;
  assign w_handshake = (r_state == S_PRESENT) && frame_ready_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_RUN;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Next-state and pending-step logic; extra step pulses merge into one flag
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    case (r_state)
      S_RUN: begin
        if (step_done_i) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (step_done_i) w_pending_nxt = 1'b1;
        if (fifo_empty_i) w_state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        if (step_done_i) w_pending_nxt = 1'b1;
        if (frame_ready_i) begin
          w_state_nxt   = (r_pending || step_done_i) ? S_FLUSH : S_RUN;
          w_pending_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = S_RUN;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

  // Working bitmap: set on in-range pops, cleared once the frame is accepted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bitmap <= '0;
    end else if (w_handshake) begin
      r_bitmap <= '0;
    end else if (w_pop && w_in_range) begin
      r_bitmap[w_idx] <= 1'b1;
    end
  end

  // Presented frame is snapshotted when FLUSH finishes and held afterwards
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_frame_bitmap <= '0;
    end else if (w_enter_present) begin
      r_frame_bitmap <= r_bitmap;
    end
  end

  // Saturating per-neuron counters; clear wins over a same-cycle increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) r_count[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < N; i++) r_count[i] <= '0;
    end else if (w_pop && w_in_range && (r_count[w_idx] != {CW{1'b1}})) begin
      r_count[w_idx] <= r_count[w_idx] + 1'b1;
    end
  end

  // Saturating count of out-of-range indices
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_drop_cnt <= '0;
    end else if (clear_i) begin
      r_drop_cnt <= '0;
    end else if (w_pop && !w_in_range && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Accepted-frame counter, wraps naturally
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_step_cnt <= '0;
    end else if (w_handshake) begin
      r_step_cnt <= r_step_cnt + 1'b1;
    end
  end

  assign fifo_rd_o      = w_pop;
  assign frame_valid_o  = (r_state == S_PRESENT);
  assign frame_bitmap_o = r_frame_bitmap;
  assign step_cnt_o     = r_step_cnt;
  assign drop_cnt_o     = r_drop_cnt;
  assign rd_count_o     = (int'(rd_idx_i) < N) ? r_count[rd_idx_i] : '0;
  assign busy_o         = (r_state != S_RUN) || r_pending || (!fifo_empty_i && en_i);

endmodule
`default_nettype wire
